// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and a
// legality helper used by the sequencer and the alu_ctl decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic alu_is_legal(input logic [3:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
      ALU_XOR, ALU_OR, ALU_AND: alu_is_legal = 1'b1;
      default:                  alu_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative left shifter: one bit per clock. start_i loads the operand and
// shift count; done_o flags the cycle whose edge performs the last shift,
// and shifted_o is the value the accumulator takes on that edge.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               done_o,
  output logic [XLEN-1:0]    shifted_o
);

  logic [XLEN-1:0]    acc_q;
  logic [SHAMT_W-1:0] cnt_q;

  // Load on start, otherwise shift and count down until the count is exhausted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= data_i;
      cnt_q <= shamt_i;
    end else if (cnt_q != '0) begin
      acc_q <= acc_q << 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o    = (cnt_q == SHAMT_W'(1));
  assign shifted_o = acc_q << 1;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides.
// ALU_SEQ_BARREL_EN: when defined, SLL completes in one cycle through a
// barrel shifter and the iterative shifter / SHIFT state are not built.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready=1)
// SHIFT | iterative SLL in progress
// DONE  | result presented (out_valid=1), waiting for out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] op_res;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

`ifndef ALU_SEQ_BARREL_EN
  logic            shift_start;
  logic            shift_done;
  logic [XLEN-1:0] shift_res;

  alu_shift_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (shift_start),
    .data_i    (op_a),
    .shamt_i   (shamt),
    .done_o    (shift_done),
    .shifted_o (shift_res)
  );
`endif

  // Single-cycle result for every code; the iterative build only uses the
  // SLL entry when the shift amount is zero.
  always_comb begin
    op_res = '0;
    case (alu_ctl)
      ALU_ADD: op_res = op_a + op_b;
      ALU_SUB: op_res = op_a - op_b;
`ifdef ALU_SEQ_BARREL_EN
      ALU_SLL: op_res = op_a << shamt;
`else
      ALU_SLL: op_res = op_a;
`endif
      ALU_SLT: op_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_XOR: op_res = op_a ^ op_b;
      ALU_OR:  op_res = op_a | op_b;
      ALU_AND: op_res = op_a & op_b;
      default: op_res = '0;
    endcase
  end

  // Next-state and result capture; results only change when entering DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_SEQ_BARREL_EN
    shift_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifndef ALU_SEQ_BARREL_EN
          if (alu_ctl == ALU_SLL && shamt != '0) begin
            shift_start = 1'b1;
            state_d     = ST_SHIFT;
          end else
`endif
          begin
            result_d  = op_res;
            zero_d    = (op_res == '0);
            illegal_d = !alu_is_legal(alu_ctl);
            state_d   = ST_DONE;
          end
        end
      end
`ifndef ALU_SEQ_BARREL_EN
      ST_SHIFT: begin
        if (shift_done) begin
          result_d  = shift_res;
          zero_d    = (shift_res == '0);
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
